// File: rtl/cmp_and_swap_if.sv
// Port bundle between the sort controller (master) and the compare-and-swap engine (slave).
// The controller owns the RAM, so it drives the read data back into the engine.
interface cmp_and_swap_if #(
    parameter int unsigned ADDR_WIDTH = 2,
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  start;
    logic [ADDR_WIDTH:0]   i;
    logic [DATA_WIDTH-1:0] read_data_1;
    logic [DATA_WIDTH-1:0] read_data_2;
    logic [ADDR_WIDTH:0]   read_addr_1;
    logic [ADDR_WIDTH:0]   read_addr_2;
    logic [ADDR_WIDTH:0]   write_addr;
    logic [DATA_WIDTH-1:0] write_data;
    logic                  we;
    logic                  finish;

    modport master (
        output start, i, read_data_1, read_data_2,
        input  read_addr_1, read_addr_2, write_addr, write_data, we, finish
    );

    modport slave (
        input  start, i, read_data_1, read_data_2,
        output read_addr_1, read_addr_2, write_addr, write_data, we, finish
    );
endinterface

// File: rtl/cmp_and_swap.sv
// Compare-and-swap engine: reads words idx and idx+1, writes them back exchanged if out of order.
// Define CMP_AND_SWAP_SIGNED_EN to compare as two's-complement instead of unsigned.
module cmp_and_swap #(
    parameter int unsigned ADDR_WIDTH = 2,
    parameter int unsigned DATA_WIDTH = 8
) (
    input logic           clk,
    input logic           reset,
    cmp_and_swap_if.slave bus
);

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StCompare = 3'd1,
        StSwap1   = 3'd2,
        StSwap2   = 3'd3,
        StDone    = 3'd4
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH:0]   idx_q, idx_d;
    logic [DATA_WIDTH-1:0] a_q, a_d;
    logic [DATA_WIDTH-1:0] b_q, b_d;
    logic [ADDR_WIDTH:0]   idx_inc;
    logic                  out_of_order;

    assign idx_inc = idx_q + {{ADDR_WIDTH{1'b0}}, 1'b1};

`ifdef CMP_AND_SWAP_SIGNED_EN
    assign out_of_order = $signed(bus.read_data_1) > $signed(bus.read_data_2);
`else
    assign out_of_order = bus.read_data_1 > bus.read_data_2;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    idx_d   = bus.i;
                    state_d = StCompare;
                end
            end
            StCompare: begin
                a_d     = bus.read_data_1;
                b_d     = bus.read_data_2;
                state_d = out_of_order ? StSwap1 : StDone;
            end
            StSwap1: state_d = StSwap2;
            StSwap2: state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Moore outputs: decoded from the registered state only.
    always_comb begin
        bus.we         = 1'b0;
        bus.finish     = 1'b0;
        bus.write_addr = '0;
        bus.write_data = '0;
        case (state_q)
            StSwap1: begin
                bus.we         = 1'b1;
                bus.write_addr = idx_q;
                bus.write_data = b_q;
            end
            StSwap2: begin
                bus.we         = 1'b1;
                bus.write_addr = idx_inc;
                bus.write_data = a_q;
            end
            StDone:  bus.finish = 1'b1;
            default: ;
        endcase
    end

    assign bus.read_addr_1 = idx_q;
    assign bus.read_addr_2 = idx_inc;

endmodule

// File: tb/tb_cmp_and_swap.sv
// Directed bench for cmp_and_swap: table of single operations, held-start, reset mid-swap, full sort.
module tb_cmp_and_swap;

    localparam int unsigned AW = 2;
    localparam int unsigned DW = 8;
`ifdef CMP_AND_SWAP_SIGNED_EN
    localparam bit SGN = 1'b1;
`else
    localparam bit SGN = 1'b0;
`endif

    typedef struct packed {
        logic [3:0][7:0] init;
        logic [2:0]      idx;
        logic            swap;
        logic [3:0][7:0] final_mem;
    } vec_t;

    logic clk;
    logic reset;
    cmp_and_swap_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_if ();

    cmp_and_swap #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    // RAM model: combinational read, write on rising edge, bulk load from the bench.
    logic [3:0][7:0] mem;
    logic [3:0][7:0] load_vals;
    logic            load_en;

    assign bus_if.read_data_1 = mem[bus_if.read_addr_1[1:0]];
    assign bus_if.read_data_2 = mem[bus_if.read_addr_2[1:0]];

    always @(posedge clk) begin
        if (load_en) mem <= load_vals;
        else if (bus_if.we) mem[bus_if.write_addr[1:0]] <= bus_if.write_data;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0][7:0] mk(input logic [7:0] w0, w1, w2, w3);
        logic [3:0][7:0] r;
        r[0] = w0; r[1] = w1; r[2] = w2; r[3] = w3;
        return r;
    endfunction

    task automatic load(input logic [3:0][7:0] v);
        @(negedge clk);
        load_vals = v;
        load_en   = 1'b1;
        @(negedge clk);
        load_en   = 1'b0;
    endtask

    // One operation; checks {we, finish, write_addr, write_data} every cycle after start.
    task automatic run_op(input logic [2:0] idx, input logic swap, input logic [7:0] a,
                          input logic [7:0] b, input bit hold, input string tag);
        int         fin_k;
        logic [12:0] exp_v, act_v;
        logic [2:0] idx1;
        idx1  = idx + 3'd1;
        fin_k = swap ? 4 : 2;
        @(negedge clk);
        bus_if.start = 1'b1;
        bus_if.i     = idx;
        @(posedge clk);
        #1;
        if (!hold) bus_if.start = 1'b0;
        for (int k = 1; k <= fin_k + 2; k++) begin
            @(negedge clk);
            exp_v = '0;
            if (swap && k == 2)      exp_v = {1'b1, 1'b0, idx, b};
            else if (swap && k == 3) exp_v = {1'b1, 1'b0, idx1, a};
            else if (k == fin_k)     exp_v = {1'b0, 1'b1, 3'd0, 8'd0};
            act_v = {bus_if.we, bus_if.finish, bus_if.write_addr, bus_if.write_data};
            check($sformatf("%s cyc%0d we/fin/wa/wd", tag, k), 32'(act_v), 32'(exp_v));
            if (hold) begin
                if (k >= fin_k) bus_if.start = 1'b0;
                else bus_if.i = (k % 2 == 1) ? 3'd2 : 3'd3;
            end
        end
    endtask

    vec_t       vecs [7];
    logic [7:0] sw   [4];

    initial begin
        vecs[0] = '{init: mk(3, 9, 0, 0), idx: 3'd0, swap: 1'b0, final_mem: mk(3, 9, 0, 0)};
        vecs[1] = '{init: mk(0, 200, 7, 0), idx: 3'd1, swap: !SGN,
                    final_mem: SGN ? mk(0, 200, 7, 0) : mk(0, 7, 200, 0)};
        vecs[2] = '{init: mk(0, 0, 8'h55, 8'h55), idx: 3'd2, swap: 1'b0,
                    final_mem: mk(0, 0, 8'h55, 8'h55)};
        vecs[3] = '{init: mk(8'h80, 1, 0, 0), idx: 3'd0, swap: !SGN,
                    final_mem: SGN ? mk(8'h80, 1, 0, 0) : mk(1, 8'h80, 0, 0)};
        vecs[4] = '{init: mk(10, 20, 255, 0), idx: 3'd2, swap: !SGN,
                    final_mem: SGN ? mk(10, 20, 255, 0) : mk(10, 20, 0, 255)};
        vecs[5] = '{init: mk(8'h7f, 8'hff, 0, 0), idx: 3'd0, swap: SGN,
                    final_mem: SGN ? mk(8'hff, 8'h7f, 0, 0) : mk(8'h7f, 8'hff, 0, 0)};
        vecs[6] = '{init: mk(9, 8, 0, 0), idx: 3'd0, swap: 1'b1, final_mem: mk(8, 9, 0, 0)};

        reset        = 1'b1;
        bus_if.start = 1'b0;
        bus_if.i     = '0;
        load_en      = 1'b0;
        load_vals    = '0;
        #12;
        check("reset we/fin/wa/wd",
              32'({bus_if.we, bus_if.finish, bus_if.write_addr, bus_if.write_data}), 32'd0);
        check("reset read_addr_1", 32'(bus_if.read_addr_1), 32'd0);
        check("reset read_addr_2", 32'(bus_if.read_addr_2), 32'd1);
        @(negedge clk);
        reset = 1'b0;

        for (int v = 0; v < 7; v++) begin
            load(vecs[v].init);
            run_op(vecs[v].idx, vecs[v].swap, vecs[v].init[vecs[v].idx[1:0]],
                   vecs[v].init[vecs[v].idx[1:0] + 2'd1], 1'b0, $sformatf("vec%0d", v));
            check($sformatf("vec%0d ram", v), 32'(mem), 32'(vecs[v].final_mem));
            check($sformatf("vec%0d idle read_addr_1", v), 32'(bus_if.read_addr_1),
                  32'(vecs[v].idx));
            check($sformatf("vec%0d idle read_addr_2", v), 32'(bus_if.read_addr_2),
                  32'(vecs[v].idx + 3'd1));
        end

        // start held high with i toggling: one op on the latched index only.
        load(mk(5, 1, 9, 2));
        run_op(3'd0, 1'b1, 8'd5, 8'd1, 1'b1, "hold");
        check("hold ram", 32'(mem), 32'(mk(1, 5, 9, 2)));

        // Async reset during SWAP2: SWAP1 already committed, so b sits at both addresses.
        load(mk(0, 200, 7, 0));
        @(negedge clk);
        bus_if.start = 1'b1;
        bus_if.i     = 3'd1;
        @(posedge clk);
        #1;
        bus_if.start = 1'b0;
        repeat (3) @(negedge clk);
        check("rst pre we/wa", 32'({bus_if.we, bus_if.write_addr}), 32'({1'b1, 3'd2}));
        #1;
        reset = 1'b1;
        #1;
        check("rst we/fin/wa/wd",
              32'({bus_if.we, bus_if.finish, bus_if.write_addr, bus_if.write_data}), 32'd0);
        check("rst read_addr_1", 32'(bus_if.read_addr_1), 32'd0);
        check("rst read_addr_2", 32'(bus_if.read_addr_2), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst ram", 32'(mem), 32'(mk(0, 7, 7, 0)));
        check("rst idle fin/we", 32'({bus_if.we, bus_if.finish}), 32'd0);

        // Full bubble sort driven like the controller would.
        load(mk(4, 3, 2, 1));
        sw[0] = 4; sw[1] = 3; sw[2] = 2; sw[3] = 1;
        for (int p = 0; p < 3; p++) begin
            for (int j = 0; j < 3 - p; j++) begin
                logic [7:0] x, y;
                logic       sx;
                x  = sw[j];
                y  = sw[j + 1];
                sx = x > y;
                run_op(3'(j), sx, x, y, 1'b0, $sformatf("sort p%0d j%0d", p, j));
                if (sx) begin
                    sw[j]     = y;
                    sw[j + 1] = x;
                end
            end
        end
        check("sort ram", 32'(mem), 32'(mk(1, 2, 3, 4)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cmp_and_swap.md
# cmp_and_swap

Compare-and-swap engine for the bubble-sort datapath. On a `start` pulse it reads two adjacent words (`i`, `i+1`) from a combinational-read dual-port RAM, compares them, and writes them back exchanged if `word[i] > word[i+1]`. It pulses `finish` when done. It sits under the sort controller, which owns the RAM and multiplexes the RAM ports to this block during the inner loop.

## Interface
- `ADDR_WIDTH`, default 2: RAM address width (log2 of array size).
- `DATA_WIDTH`, default 8: word width.

- `clk`  in  1  clock.
- `reset`  in  1  reset, asynchronous, active-high.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `i`  in  ADDR_WIDTH+1  index of first element; sampled with `start`.
- `read_data_1`  in  DATA_WIDTH  RAM port-1 data (word at `read_addr_1`), combinational.
- `read_data_2`  in  DATA_WIDTH  RAM port-2 data (word at `read_addr_2`), combinational.
- `read_addr_1`  out  ADDR_WIDTH+1  equals latched index.
- `read_addr_2`  out  ADDR_WIDTH+1  equals latched index + 1.
- `write_addr`  out  ADDR_WIDTH+1  RAM write address; valid while `we`=1.
- `write_data`  out  DATA_WIDTH  RAM write data; valid while `we`=1.
- `we`  out  1  RAM write enable; the RAM writes on the rising `clk` edge.
- `finish`  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, COMPARE, SWAP1, SWAP2, DONE.
- **IDLE:**
  - `we`=0, `finish`=0.
  - On `start`=1: latch `i` into `idx` and go to COMPARE.
- **COMPARE:**
  - Capture `read_data_1` into `a` and `read_data_2` into `b`.
  - If `a > b` (unsigned), go to SWAP1; otherwise go to DONE.
  - Equal words are never swapped.
- **SWAP1:** `we`=1, `write_addr`=`idx`, `write_data`=`b`. Go to SWAP2.
- **SWAP2:** `we`=1, `write_addr`=`idx+1`, `write_data`=`a`. Go to DONE.
- **DONE:** `finish`=1 for exactly one cycle, then go to IDLE.
- Address arithmetic:
  - `idx+1` is computed in ADDR_WIDTH+1 bits.
  - The caller truncates to ADDR_WIDTH and guarantees `i` ≤ 2^ADDR_WIDTH − 2. No wrap handling is done internally.
- `start` outside IDLE is ignored. `i` changes while busy have no effect.
- Read addresses are driven from `idx` in every state, including IDLE.
- `write_addr` and `write_data` are 0 when `we`=0.
- No illegal-state lockup: an unused encoding returns to IDLE.

## Timing
- Reset values:
  - state=IDLE; `idx`, `a`, `b` = 0.
  - `we`=0, `finish`=0, `write_addr`=0, `write_data`=0, `read_addr_1`=0, `read_addr_2`=1.
- `start` is sampled at edge T.
  - Compare happens in cycle T+1.
  - No swap: `finish` is high during cycle T+2.
  - Swap: writes occur in cycles T+2 and T+3; `finish` is high during cycle T+4.
- Both RAM writes complete before `finish` rises. The next `start` may be accepted in the cycle after `finish`.
- Reset mid-swap aborts immediately with `we`=0. If SWAP1 had already committed, the RAM holds `b` at both `idx` and `idx+1`. Recovering from this is the controller's responsibility.
- Outputs are registered-state decodes (Moore). There is no combinational path from `start` to `we` or `finish`.

## Configuration
- `CMP_AND_SWAP_SIGNED_EN`:
  - Defined: the COMPARE test is a two's-complement signed `a > b`.
  - Undefined (default): unsigned compare.
- Swap ordering and timing are identical in both builds.

## Test plan
- No swap: RAM[0]=3, RAM[1]=9, `start` with `i`=0 → no `we` pulse, `finish` high at T+2, RAM unchanged.
- Swap: RAM[1]=200, RAM[2]=7, `i`=1 → `we` at T+2 (addr 1, data 7) and T+3 (addr 2, data 200), `finish` at T+4, RAM[1]=7, RAM[2]=200.
- Equal: RAM[2]=RAM[3]=0x55, `i`=2 → no writes, `finish` at T+2.
- Signedness: RAM[0]=0x80, RAM[1]=0x01 → unsigned build swaps. With `CMP_AND_SWAP_SIGNED_EN` defined, no swap.
- Robustness: `start` held high through the whole operation, with `i` toggled → exactly one operation on the latched `i`, single-cycle `finish`. Asynchronous reset asserted during SWAP2 → `we` drops immediately, block returns to IDLE, all reset values restored.
- Full pass: drive a 4-word bubble sort of {4,3,2,1} via the controller → RAM ends {1,2,3,4} and each `finish` is one cycle.
